seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 36 +++
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and active-low glyph constants for the segment scan controller.
// Segment vectors are ordered [0:6] = a..g; a 0 bit lights the segment.
package seg_scan_pkg;

   typedef logic [3:0] digit_t;
   typedef logic [0:6] seg_t;

   localparam seg_t GLYPH_0     = 7'b0000001;
   localparam seg_t GLYPH_1     = 7'b1001111;
   localparam seg_t GLYPH_2     = 7'b0010010;
   localparam seg_t GLYPH_3     = 7'b0000110;
   localparam seg_t GLYPH_4     = 7'b1001100;
   localparam seg_t GLYPH_5     = 7'b0100100;
   localparam seg_t GLYPH_6     = 7'b0100000;
   localparam seg_t GLYPH_7     = 7'b0001111;
   localparam seg_t GLYPH_8     = 7'b0000000;
   localparam seg_t GLYPH_9     = 7'b0000100;
   localparam seg_t GLYPH_A     = 7'b0001000;
   localparam seg_t GLYPH_B     = 7'b1100000;
   localparam seg_t GLYPH_C     = 7'b0110001;
   localparam seg_t GLYPH_D     = 7'b1000010;
   localparam seg_t GLYPH_E     = 7'b0110000;
   localparam seg_t GLYPH_F     = 7'b0111000;
   localparam seg_t GLYPH_DASH  = 7'b1111110;
   localparam seg_t GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low 7-segment decoder.
// Codes above 9 show hex letters when hex=1, otherwise a dash.
module seg7_decode
   import seg_scan_pkg::*;
(
   input  digit_t code,
   input  logic   hex,
   input  logic   blank,
   output seg_t   seg
);

   always_comb begin
      seg = GLYPH_BLANK;
      if (!blank) begin
         case (code)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = hex ? GLYPH_A : GLYPH_DASH;
            4'hB:    seg = hex ? GLYPH_B : GLYPH_DASH;
            4'hC:    seg = hex ? GLYPH_C : GLYPH_DASH;
            4'hD:    seg = hex ? GLYPH_D : GLYPH_DASH;
            4'hE:    seg = hex ? GLYPH_E : GLYPH_DASH;
            default: seg = hex ? GLYPH_F : GLYPH_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digits, PWM brightness
// and leading-zero blanking. Define SEG_SCAN_BLINK_EN for per-digit blinking.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int CDBITS     = 18,
   parameter int BW         = 3,
   parameter int HEX        = 0,
   parameter int BLINK_LOG2 = 6
)(
   input  logic              ck,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [4*NDIG-1:0] data,
   input  logic [NDIG-1:0]   dp,
   input  logic              lzb,
   input  logic [BW-1:0]     bright,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [NDIG-1:0]   blink,
`endif
   output logic [0:6]        seg,
   output logic              dp_n,
   output logic [NDIG-1:0]   an,
   output logic              frame_done
);

   localparam int IW = $clog2(NDIG);

   if (NDIG < 2 || NDIG > 8 || BW < 1 || BW >= CDBITS || BLINK_LOG2 < 0) begin : g_bad_param
      $error("seg_scan_ctrl: illegal parameter combination");
   end

   logic [CDBITS-1:0]       pc_q, pc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    pend_q, pend_d;
   logic [NDIG-1:0][3:0]    pbuf_q, pbuf_d, dbuf_q, dbuf_d;
   logic [NDIG-1:0]         pdp_q, pdp_d, ddp_q, ddp_d;
   seg_t                    seg_q, seg_d;
   logic                    dp_n_q, dp_n_d;
   logic [NDIG-1:0]         an_q, an_d;
   logic                    fd_q, fd_d;

   logic                    tick, boundary, lit, blink_off, lz_run;
   logic [BW-1:0]           ph;
   logic [NDIG-1:0]         lz_mask;
   seg_t                    seg_dec;

   assign tick     = &pc_q;
   assign boundary = tick && (idx_q == IW'(NDIG-1));
   assign ph       = pc_q[CDBITS-1 -: BW];

   // Counters and the pending/display double buffer.
   always_comb begin
      pc_d   = pc_q + CDBITS'(1);
      idx_d  = idx_q;
      pend_d = pend_q;
      pbuf_d = pbuf_q;
      pdp_d  = pdp_q;
      dbuf_d = dbuf_q;
      ddp_d  = ddp_q;
      if (tick)
         idx_d = (idx_q == IW'(NDIG-1)) ? '0 : idx_q + IW'(1);
      if (boundary && pend_q) begin
         dbuf_d = pbuf_q;
         ddp_d  = pdp_q;
         pend_d = 1'b0;
      end
      // A load on the boundary cycle stays pending while the older value moves over.
      if (load) begin
         pbuf_d = data;
         pdp_d  = dp;
         pend_d = 1'b1;
      end
   end

   // Leading zeros blank from the top digit down; digit 0 always shows.
   always_comb begin
      lz_run  = lzb;
      lz_mask = '0;
      for (int k = NDIG-1; k > 0; k--) begin
         lz_run     = lz_run && (dbuf_q[k] == 4'h0);
         lz_mask[k] = lz_run;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   logic [BLINK_LOG2:0] fcnt_q, fcnt_d;

   assign fcnt_d    = boundary ? fcnt_q + (BLINK_LOG2+1)'(1) : fcnt_q;
   assign blink_off = fcnt_q[BLINK_LOG2] && blink[idx_q];

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) fcnt_q <= '0;
      else        fcnt_q <= fcnt_d;
   end
`else
   assign blink_off = 1'b0;
`endif

   seg7_decode u_dec (
      .code  (dbuf_q[idx_q]),
      .hex   (HEX != 0),
      .blank (lz_mask[idx_q] | blink_off),
      .seg   (seg_dec)
   );

   // Phase 0 of each slot is dead time so the previous digit's glyph never ghosts.
   always_comb begin
      lit    = en && (ph != '0) && (ph <= bright);
      an_d   = '1;
      if (lit)
         an_d[idx_q] = 1'b0;
      seg_d  = seg_dec;
      dp_n_d = ~ddp_q[idx_q] | blink_off;
      fd_d   = boundary;
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= '0;
         idx_q  <= '0;
         pend_q <= 1'b0;
         pbuf_q <= '0;
         pdp_q  <= '0;
         dbuf_q <= '0;
         ddp_q  <= '0;
         seg_q  <= GLYPH_BLANK;
         dp_n_q <= 1'b1;
         an_q   <= '1;
         fd_q   <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         idx_q  <= idx_d;
         pend_q <= pend_d;
         pbuf_q <= pbuf_d;
         pdp_q  <= pdp_d;
         dbuf_q <= dbuf_d;
         ddp_q  <= ddp_d;
         seg_q  <= seg_d;
         dp_n_q <= dp_n_d;
         an_q   <= an_d;
         fd_q   <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, CDBITS=4, BW=2, HEX=0) against a
// time-indexed reference model: pc/idx are derived from cycles since reset.
module tb_seg_scan_ctrl;

   logic        ck = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1, load = 1'b0, lzb = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  dp = '0;
   logic [1:0]  bright = 2'd3;
   logic [0:6]  seg;
   logic        dp_n, frame_done;
   logic [3:0]  an;
`ifdef SEG_SCAN_BLINK_EN
   logic [3:0]  blink = '0;
`endif

   int checks = 0;
   int failures = 0;

   seg_scan_ctrl #(.NDIG(4), .CDBITS(4), .BW(2), .HEX(0), .BLINK_LOG2(1)) dut (
      .ck(ck), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp(dp),
      .lzb(lzb), .bright(bright),
`ifdef SEG_SCAN_BLINK_EN
      .blink(blink),
`endif
      .seg(seg), .dp_n(dp_n), .an(an), .frame_done(frame_done)
   );

   always #5 ck = ~ck;

   function automatic logic [0:6] glyph(int unsigned c);
      case (c)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111110;
      endcase
   endfunction

   // Slot = 16 cycles, phase = upper two prescaler bits, digit = slot number mod 4.
   function automatic logic [3:0] exp_an(int unsigned t, logic e, logic [1:0] br);
      int unsigned ph = (t % 16) / 4;
      int unsigned d  = (t / 16) % 4;
      if (e && ph >= 1 && ph <= br) return ~(4'b0001 << d);
      return 4'b1111;
   endfunction

   function automatic logic [0:6] exp_seg(int unsigned t, logic [15:0] disp, logic lz);
      int unsigned d = (t / 16) % 4;
      logic [15:0] upper = disp >> (4 * d);
      if (lz && d != 0 && upper == 16'h0) return 7'b1111111;
      return glyph(int'(upper[3:0]));
   endfunction

   int unsigned m_t;
   logic [15:0] m_disp, m_pbuf;
   logic [3:0]  m_ddp, m_pdp;
   logic        m_pend;
   logic [3:0]  an_e;
   logic [0:6]  seg_e;
   logic        dp_e, fd_e;

   always @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         m_t <= 0; m_pend <= 1'b0; m_pbuf <= '0; m_pdp <= '0; m_disp <= '0; m_ddp <= '0;
         an_e <= 4'hF; seg_e <= 7'h7F; dp_e <= 1'b1; fd_e <= 1'b0;
      end else begin
         m_t   <= m_t + 1;
         an_e  <= exp_an(m_t, en, bright);
         seg_e <= exp_seg(m_t, m_disp, lzb);
         dp_e  <= ~m_ddp[2'((m_t / 16) % 4)];
         fd_e  <= (m_t % 64 == 63);
         if (m_t % 64 == 63 && m_pend) begin m_disp <= m_pbuf; m_ddp <= m_pdp; end
         if (load) begin m_pbuf <= data; m_pdp <= dp; m_pend <= 1'b1; end
         else if (m_t % 64 == 63) m_pend <= 1'b0;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; bright = 2'd3; lzb = 1'b0; load = 1'b0; data = '0; dp = '0;
      repeat (3) @(negedge ck);
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
      checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
      checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
      rst_n = 1'b1;
   endtask

   task automatic test_digits();
      logic [0:6] want;
      int seen [4] = '{0, 0, 0, 0};
      for (int i = 0; i < 256; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++;
            $display("FAIL digits t=%0d got an=%b seg=%b dp=%b fd=%b exp an=%b seg=%b dp=%b fd=%b",
                     m_t, an, seg, dp_n, frame_done, an_e, seg_e, dp_e, fd_e);
         end
         if (i >= 128 && an != 4'hF) begin
            case (an)
               4'b1110: begin want = 7'b1001100; seen[0]++; end
               4'b1101: begin want = 7'b0000110; seen[1]++; end
               4'b1011: begin want = 7'b0010010; seen[2]++; end
               default: begin want = 7'b1001111; seen[3]++; end
            endcase
            checks++;
            if (seg !== want) begin failures++; $display("FAIL digits_glyph an=%b got=%b exp=%b", an, seg, want); end
         end
         load = (i == 0); data = 16'h1234; dp = 4'b0010;
      end
      load = 1'b0;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (seen[d] != 24) begin failures++; $display("FAIL digits_scan digit=%0d got=%0d exp=24", d, seen[d]); end
      end
   endtask

   task automatic test_bright();
      int cnt [4];
      int tot;
      bright = 2'd1;
      cnt = '{0, 0, 0, 0};
      for (int i = 0; i < 64; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++; $display("FAIL bright1 t=%0d got an=%b exp an=%b", m_t, an, an_e);
         end
         for (int d = 0; d < 4; d++) if (an[d] == 1'b0) cnt[d]++;
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (cnt[d] != 4) begin failures++; $display("FAIL bright1_duty digit=%0d got=%0d exp=4", d, cnt[d]); end
      end
      bright = 2'd0;
      tot = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++; $display("FAIL bright0 t=%0d got an=%b exp an=%b", m_t, an, an_e);
         end
         if (an != 4'hF) tot++;
      end
      checks++;
      if (tot != 0) begin failures++; $display("FAIL bright0_dark got=%0d exp=0", tot); end
      bright = 2'd3;
   endtask

   task automatic test_lzb();
      logic [0:6] want;
      lzb = 1'b1;
      for (int i = 0; i < 192; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++; $display("FAIL lzb t=%0d got an=%b seg=%b exp an=%b seg=%b", m_t, an, seg, an_e, seg_e);
         end
         if (i >= 128 && an != 4'hF) begin
            case (an)
               4'b1110: want = 7'b0000001;
               4'b1101: want = 7'b0001111;
               default: want = 7'b1111111;
            endcase
            checks++;
            if (seg !== want) begin failures++; $display("FAIL lzb_glyph an=%b got=%b exp=%b", an, seg, want); end
         end
         load = (i == 0); data = 16'h0070; dp = 4'b0000;
      end
      load = 1'b0; lzb = 1'b0;
   endtask

   task automatic test_midload();
      int unsigned lf = 0;
      int unsigned fo;
      logic loaded = 1'b0;
      logic [0:6] want;
      for (int i = 0; i < 260; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++; $display("FAIL midload t=%0d got an=%b seg=%b exp an=%b seg=%b", m_t, an, seg, an_e, seg_e);
         end
         fo = (m_t - 1) / 64;
         if (loaded && an != 4'hF && (fo == lf || fo == lf + 1)) begin
            if (fo == lf) want = (an == 4'b1101) ? 7'b0001111 : 7'b0000001;
            else          want = (an == 4'b1110 || an == 4'b1101) ? 7'b1111110 : 7'b0000001;
            checks++;
            if (seg !== want) begin failures++; $display("FAIL midload_glyph an=%b got=%b exp=%b", an, seg, want); end
         end
         load = 1'b0;
         if (!loaded && m_t % 64 == 30) begin
            load = 1'b1; data = 16'h00AB; loaded = 1'b1; lf = m_t / 64;
         end
      end
      load = 1'b0;
   endtask

   task automatic test_back_to_back();
      int unsigned f0 = m_t / 64 + 1;
      int unsigned fo;
      logic [0:6] want;
      for (int i = 0; i < 400 && m_t < (f0 + 4) * 64 + 2; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++; $display("FAIL b2b t=%0d got an=%b seg=%b exp an=%b seg=%b", m_t, an, seg, an_e, seg_e);
         end
         fo = (m_t - 1) / 64;
         if (an != 4'hF && fo >= f0 + 1 && fo <= f0 + 3) begin
            want = (fo == f0 + 3) ? 7'b0000110 : 7'b0010010;
            checks++;
            if (seg !== want) begin failures++; $display("FAIL b2b_glyph frame=%0d got=%b exp=%b", fo - f0, seg, want); end
         end
         load = 1'b0;
         if (m_t / 64 == f0 && m_t % 64 == 10) begin load = 1'b1; data = 16'h1111; end
         if (m_t / 64 == f0 && m_t % 64 == 20) begin load = 1'b1; data = 16'h2222; end
         if (m_t / 64 == f0 + 1 && m_t % 64 == 63) begin load = 1'b1; data = 16'h3333; end
      end
      load = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic first = 1'b1;
      int guard = 0;
      load = 1'b1; data = 16'h5555;
      @(negedge ck);
      load = 1'b0;
      while (m_t % 16 != 6 && guard < 64) begin @(negedge ck); guard++; end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL rstmid_an got=%b exp=1111", an); end
      checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL rstmid_seg got=%b exp=1111111", seg); end
      @(negedge ck);
      rst_n = 1'b1;
      for (int i = 0; i < 140; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++; $display("FAIL rstmid t=%0d got an=%b seg=%b exp an=%b seg=%b", m_t, an, seg, an_e, seg_e);
         end
         if (an != 4'hF) begin
            if (first) begin
               checks++;
               if (an !== 4'b1110) begin failures++; $display("FAIL rstmid_idx got=%b exp=1110", an); end
               first = 1'b0;
            end
            checks++;
            if (seg !== 7'b0000001) begin failures++; $display("FAIL rstmid_lost got=%b exp=0000001", seg); end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2500; i++) begin
         @(negedge ck);
         checks++;
         if ({an, seg, dp_n, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
            failures++;
            $display("FAIL random t=%0d got an=%b seg=%b dp=%b fd=%b exp an=%b seg=%b dp=%b fd=%b",
                     m_t, an, seg, dp_n, frame_done, an_e, seg_e, dp_e, fd_e);
         end
         load = ($urandom_range(0, 19) == 0);
         for (int k = 0; k < 4; k++)
            data[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
         dp = 4'($urandom);
         if ($urandom_range(0, 63) == 0) en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) bright = 2'($urandom);
         if ($urandom_range(0, 63) == 0) lzb = 1'($urandom);
      end
      load = 1'b0; en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_digits();
      test_bright();
      test_lzb();
      test_midload();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at checks=%0d", checks);
      $fatal(1);
   end

endmodule
